// File: rtl/spi_slave_device.sv
// spi_slave_device: SPI mode-0 responder for BITS-wide frames, MSB first.
// SCK, MOSI and CSbar are oversampled in the SYS_CLK domain. The transmit
// word is popped from a FIFO-style source when a frame starts. The received
// word is presented on DATA_RX with a one-cycle RX_FIN strobe.
//
// Ports:
//   SYS_CLK, reset      system clock, asynchronous active-high reset
//   SCK, MOSI, CSbar    SPI pins from the master (SCK <= SYS_CLK/8)
//   MISO, MISO_OE       serial data to the master, plus its drive enable
//   DATA_TX, TX_VALID   transmit word source (dout, ~empty)
//   TX_RD               one-cycle pop to the source
//   DATA_RX, RX_FIN     last complete received word, one-cycle update strobe
//   BUSY                state is not IDLE
//   UNDERRUN            sticky: a frame started with no word available
//   FRAME_ERR           one-cycle pulse when CSbar rose mid-frame
module spi_slave_device #(
  parameter int BITS = 16
) (
  input  logic            SYS_CLK,
  input  logic            reset,
  input  logic            SCK,
  input  logic            MOSI,
  input  logic            CSbar,
  output logic            MISO,
  output logic            MISO_OE,
  input  logic [BITS-1:0] DATA_TX,
  input  logic            TX_VALID,
  output logic            TX_RD,
  output logic [BITS-1:0] DATA_RX,
  output logic            RX_FIN,
  output logic            BUSY,
  output logic            UNDERRUN,
  output logic            FRAME_ERR
);
  localparam int CW = $clog2(BITS) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  // [0],[1] synchronise, [2] is the previous synchronised value for edges.
  logic [2:0]      sck_q, cs_q;
  // MOSI is only sampled, never edge-detected, so two stages suffice.
  logic [1:0]      mosi_q;
  // Fills with ones after reset; once fill_q[1] is set, cs_q[1] holds a
  // real pin sample rather than its reset value.
  logic [1:0]      fill_q;
  logic            armed_q;
  logic [BITS-1:0] tx_q, tx_d, rx_q, rx_d, data_rx_q, data_rx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_rd_q, tx_rd_d, rx_fin_q, rx_fin_d;
  logic            und_q, und_d, ferr_q, ferr_d;

  logic            sck_rise, sck_fall, cs_rise, cs_fall;
  logic [BITS-1:0] rx_next;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  // A fall is only honoured once CSbar has genuinely been seen high, so a
  // frame in progress at reset release is never joined.
  assign cs_fall  = ~cs_q[1] & cs_q[2] & armed_q;
  assign rx_next  = {rx_q[BITS-2:0], mosi_q[1]};

  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      sck_q     <= '0;
      mosi_q    <= '0;
      cs_q      <= '1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      cnt_q     <= '0;
      tx_rd_q   <= 1'b0;
      rx_fin_q  <= 1'b0;
      und_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sck_q     <= {sck_q[1:0], SCK};
      mosi_q    <= {mosi_q[0], MOSI};
      cs_q      <= {cs_q[1:0], CSbar};
      fill_q    <= {fill_q[0], 1'b1};
      armed_q   <= armed_q | (fill_q[1] & cs_q[1]);
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      cnt_q     <= cnt_d;
      tx_rd_q   <= tx_rd_d;
      rx_fin_q  <= rx_fin_d;
      und_q     <= und_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    cnt_d     = cnt_q;
    tx_rd_d   = 1'b0;
    rx_fin_d  = 1'b0;
    und_d     = und_q;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (TX_VALID) begin
            tx_d    = DATA_TX;
            tx_rd_d = 1'b1;
          end else begin
            tx_d  = '0;
            und_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // CSbar rise wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BITS - 1)) begin
            data_rx_d = rx_next;
            rx_fin_d  = 1'b1;
            state_d   = DONE;
          end
        end else if (sck_fall && cnt_q != '0 && cnt_q < CW'(BITS)) begin
          // Mode 0: the next bit is presented on the falling edge; the
          // first bit was loaded at frame start.
          tx_d = tx_q << 1;
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO      = (state_q == SHIFT) & tx_q[BITS-1];
  assign MISO_OE   = (state_q != IDLE);
  assign BUSY      = (state_q != IDLE);
  assign TX_RD     = tx_rd_q;
  assign DATA_RX   = data_rx_q;
  assign RX_FIN    = rx_fin_q;
  assign UNDERRUN  = und_q;
  assign FRAME_ERR = ferr_q;
endmodule

// File: tb/tb_spi_slave_device.sv
// Bench for spi_slave_device: a mode-0 master at SYS_CLK/8 and a FIFO
// source, with expectations taken from frame-level rules (word sent/received,
// pops, strobes, sticky underrun).
module tb_spi_slave_device;
  logic        SYS_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        SCK = 1'b0, MOSI = 1'b0, CSbar = 1'b1;
  logic        MISO, MISO_OE, TX_RD, RX_FIN, BUSY, UNDERRUN, FRAME_ERR, TX_VALID;
  logic [15:0] DATA_TX, DATA_RX;

  int checks = 0, failures = 0;
  int rxfin_cnt = 0, txrd_cnt = 0, ferr_cnt = 0;

  logic [15:0] fifo_mem [0:127];
  int          wr_ptr = 0, rd_ptr = 0;

  logic [15:0] exp_rx = 16'h0;
  logic        exp_und = 1'b0;

  always #5 SYS_CLK = ~SYS_CLK;

  assign TX_VALID = (rd_ptr != wr_ptr);
  assign DATA_TX  = fifo_mem[rd_ptr[6:0]];

  spi_slave_device #(.BITS(16)) dut (
    .SYS_CLK(SYS_CLK), .reset(reset), .SCK(SCK), .MOSI(MOSI), .CSbar(CSbar),
    .MISO(MISO), .MISO_OE(MISO_OE), .DATA_TX(DATA_TX), .TX_VALID(TX_VALID),
    .TX_RD(TX_RD), .DATA_RX(DATA_RX), .RX_FIN(RX_FIN), .BUSY(BUSY),
    .UNDERRUN(UNDERRUN), .FRAME_ERR(FRAME_ERR)
  );

  // Pulse monitors and FIFO pop, sampled just after each active edge.
  always @(posedge SYS_CLK) begin
    #1;
    if (RX_FIN) rxfin_cnt++;
    if (FRAME_ERR) ferr_cnt++;
    if (TX_RD) begin
      txrd_cnt++;
      if (rd_ptr != wr_ptr) rd_ptr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    fifo_mem[wr_ptr[6:0]] = v;
    wr_ptr++;
  endtask

  task automatic chk_zero(input string tag);
    check(tag, {25'd0, MISO, MISO_OE, TX_RD, RX_FIN, BUSY, UNDERRUN, FRAME_ERR}, 32'd0);
    check({tag, "_rx"}, DATA_RX, 32'd0);
  endtask

  // Master clocks n bits of mw out MSB first, sampling MISO on each SCK rise.
  task automatic shift_bits(input logic [15:0] mw, input int n, output logic [15:0] got);
    got = 16'h0;
    for (int i = 0; i < n; i++) begin
      MOSI = mw[15-i];
      repeat (4) @(negedge SYS_CLK);
      SCK = 1'b1;
      got[15-i] = MISO;
      repeat (4) @(negedge SYS_CLK);
      SCK = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] mw, input int nclk, input int gap);
    logic [15:0] head, got, mask;
    logic        empty;
    int          rf0, rd0, fe0;
    empty = (rd_ptr == wr_ptr);
    head  = empty ? 16'h0 : fifo_mem[rd_ptr[6:0]];
    rf0 = rxfin_cnt; rd0 = txrd_cnt; fe0 = ferr_cnt;
    CSbar = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    shift_bits(mw, nclk, got);
    repeat (4) @(negedge SYS_CLK);
    CSbar = 1'b1;
    repeat (gap) @(negedge SYS_CLK);
    exp_und = exp_und | empty;
    if (nclk == 16) exp_rx = mw;
    mask = 16'hFFFF << (16 - nclk);
    check("miso_word", got & mask, head & mask);
    check("tx_rd_pulses", rd0 == txrd_cnt ? 0 : txrd_cnt - rd0, empty ? 0 : 1);
    check("rx_fin_pulses", rxfin_cnt - rf0, (nclk == 16) ? 1 : 0);
    check("frame_err_pulses", ferr_cnt - fe0, (nclk == 16) ? 0 : 1);
    check("data_rx", DATA_RX, exp_rx);
    check("underrun", UNDERRUN, exp_und);
    check("busy_after", BUSY, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [15:0] got;
    // Reset with CSbar high.
    repeat (3) @(negedge SYS_CLK);
    chk_zero("reset_idle");
    reset = 1'b0;
    repeat (6) @(negedge SYS_CLK);

    // Basic frame.
    push(16'hA5C3);
    frame(16'h1234, 16, 4);

    // Underrun, then sticky over a normal frame.
    frame(16'h5555, 16, 4);
    push(16'h7E81);
    frame(16'hC001, 16, 4);

    // Aborted frame after 7 SCK clocks.
    push(16'h3C3C);
    frame(16'hFFFF, 7, 6);

    // CSbar held low across reset release: nothing may start.
    reset = 1'b1;
    CSbar = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    exp_rx = 16'h0; exp_und = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge SYS_CLK);
      check("oe_cs_low", MISO_OE, 0);
    end
    CSbar = 1'b1;
    repeat (6) @(negedge SYS_CLK);
    push(16'h9A6B);
    frame(16'h4D2E, 16, 4);

    // Reset mid-frame after 9 SCK clocks.
    push(16'h5A5A);
    CSbar = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    shift_bits(16'hFFFF, 9, got);
    check("busy_mid", BUSY, 1);
    reset = 1'b1;
    #1;
    chk_zero("reset_async");
    CSbar = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    reset = 1'b0;
    exp_rx = 16'h0; exp_und = 1'b0;
    repeat (6) @(negedge SYS_CLK);
    push(16'h0F0F);
    frame(16'hBEEF, 16, 4);

    // Back-to-back frames with a 3-cycle CSbar gap.
    for (int i = 1; i <= 4; i++) push(16'(i));
    for (int i = 0; i < 4; i++) frame(16'($urandom), 16, 3);

    // Randomised frames.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(3) != 0) push(16'($urandom));
      frame(16'($urandom), ($urandom_range(3) == 0) ? $urandom_range(1, 15) : 16,
            $urandom_range(3, 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
